// File: rtl/ulpi_capture_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ulpi_capture_sched
//  Description : ULPI receive capture controller. Gates the receiver with
//                read_allow, tracks sticky FIFO overflow, and drains the INFO
//                and DATA FIFOs into framed bytes for the UART TX path:
//                SYNC, INFO_HI, INFO_LO, <count data bytes>, CSUM.
//  Revision    : 1.0 - initial release
// ============================================================================
module ulpi_capture_sched #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CNT_W     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clr_ovf,
    output logic        read_allow,
    output logic        overflow,
    output logic        busy,
    input  logic        info_empty,
    input  logic        info_full,
    output logic        info_re,
    input  logic [15:0] info_data,
    input  logic        data_empty,
    input  logic        data_full,
    output logic        data_re,
    input  logic [7:0]  data_byte,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INFO_RD  = 4'd1,
        S_INFO_LAT = 4'd2,
        S_SYNC     = 4'd3,
        S_HI       = 4'd4,
        S_LO       = 4'd5,
        S_DATA_RD  = 4'd6,
        S_DATA_LAT = 4'd7,
        S_DATA_TX  = 4'd8,
        S_CSUM     = 4'd9
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        info_q,  info_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [7:0]         csum_q,  csum_d;
    logic [7:0]         byte_q,  byte_d;
    logic               ovf_q;
    logic               w_ovf_set;

    // The set term looks at the host enable rather than the gated read_allow,
    // so a full flag that coincides with clr_ovf keeps overflow asserted
    // instead of clearing it for a cycle and re-setting it.
    assign w_ovf_set  = enable && (info_full || data_full);
    assign overflow   = ovf_q;
    // Receiver is held off while in reset as well as after an overflow.
    assign read_allow = rst && enable && !ovf_q;
    assign busy       = (state_q != S_IDLE);

    // Sticky overflow flag; set has priority over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (w_ovf_set) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    // Frame state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            info_q  <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            info_q  <= info_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            byte_q  <= byte_d;
        end
    end

    // Next-state, FIFO read strobes and TX byte selection. Each presenting
    // state holds tx_valid and its byte until tx_ready completes the transfer.
    always_comb begin
        state_d  = state_q;
        info_d   = info_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        byte_d   = byte_q;
        info_re  = 1'b0;
        data_re  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (!info_empty) begin
                    info_re = 1'b1;
                    state_d = S_INFO_RD;
                end
            end
            S_INFO_RD: begin
                // FIFO read data is valid in the cycle after the strobe.
                info_d  = info_data;
                state_d = S_INFO_LAT;
            end
            S_INFO_LAT: begin
                cnt_d   = info_q[CNT_W-1:0];
                csum_d  = 8'h00;
                state_d = S_SYNC;
            end
            S_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) begin
                    state_d = S_HI;
                end
            end
            S_HI: begin
                tx_valid = 1'b1;
                tx_data  = info_q[15:8];
                if (tx_ready) begin
                    csum_d  = csum_q ^ info_q[15:8];
                    state_d = S_LO;
                end
            end
            S_LO: begin
                tx_valid = 1'b1;
                tx_data  = info_q[7:0];
                if (tx_ready) begin
                    csum_d  = csum_q ^ info_q[7:0];
                    state_d = (cnt_q != c_cnt_zero) ? S_DATA_RD : S_CSUM;
                end
            end
            S_DATA_RD: begin
                if (!data_empty) begin
                    data_re = 1'b1;
                    state_d = S_DATA_LAT;
                end
            end
            S_DATA_LAT: begin
                byte_d  = data_byte;
                state_d = S_DATA_TX;
            end
            S_DATA_TX: begin
                tx_valid = 1'b1;
                tx_data  = byte_q;
                if (tx_ready) begin
                    csum_d  = csum_q ^ byte_q;
                    cnt_d   = cnt_q - c_cnt_one;
                    state_d = (cnt_q != c_cnt_one) ? S_DATA_RD : S_CSUM;
                end
            end
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
